alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 52 +++++
 rtl/alu_issue_stage.sv | 95 +++++++++
 tb/tb_alu_issue_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcodes and FSM state.
package alu_pkg;

  localparam int OPW_DEF  = 4;
  localparam int RESW_DEF = 2 * OPW_DEF;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_MOD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Power-of-two command FIFO with registered count; head is read combinationally.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Queues ALU commands, drives one at a time to an external combinational ALU
// and holds each result until the downstream handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OPW-1:0]     cmd_a,
  input  logic [OPW-1:0]     cmd_b,
  input  logic [2:0]         cmd_op,
  output logic [OPW-1:0]     alu_a,
  output logic [OPW-1:0]     alu_b,
  output logic [2:0]         alu_op,
  input  logic [2*OPW-1:0]   alu_res,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*OPW-1:0]   res_data,
  output logic [2:0]         res_op,
  output logic               busy,
  output logic [7:0]         issue_cnt,
  output alu_state_t         fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and its payload never change while waiting for ready.
  localparam int CW = OPW + OPW + 3;
  localparam int AW = $clog2(DEPTH);

  alu_state_t    state;
  logic [CW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW:0]   count;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && ((state == ST_IDLE) || ((state == ST_HOLD) && res_ready));
  assign busy      = (count != '0) || (state != ST_IDLE);
  assign fsm_state = state;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({cmd_op, cmd_a, cmd_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      issue_cnt <= '0;
    end else begin
      if (pop) begin
        {alu_op, alu_a, alu_b} <= head;
        issue_cnt              <= issue_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: if (!empty) state <= ST_EXEC;
        ST_EXEC: begin
          res_data  <= alu_res;
          res_op    <= alu_op;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        // res_valid drops on every handshake so a result is never presented twice.
        ST_HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= empty ? ST_IDLE : ST_EXEC;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and result scoreboard.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int OPW = 4;
  localparam int RW  = 2 * OPW;

  logic           clk;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_a;
  logic [OPW-1:0] cmd_b;
  logic [2:0]     cmd_op;
  logic [OPW-1:0] alu_a;
  logic [OPW-1:0] alu_b;
  logic [2:0]     alu_op;
  logic [RW-1:0]  alu_res;
  logic           res_valid;
  logic           res_ready;
  logic [RW-1:0]  res_data;
  logic [2:0]     res_op;
  logic           busy;
  logic [7:0]     issue_cnt;
  alu_state_t     fsm_state;

  typedef struct {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [2:0]     op;
    logic [RW-1:0]  exp;
  } vec_t;

  vec_t vecs[12];

  logic [RW+2:0] exp_q[$];
  int            pass_cnt = 0;
  int            check_cnt = 0;
  int            accepted = 0;
  int            cyc = 0;
  int            last_res_cyc = 0;
  int            prev_res_cyc = 0;
  logic          hold_pending = 1'b0;
  logic [RW+2:0] hold_val;
  logic          rand_done = 1'b0;

  alu_issue_stage #(.DEPTH(4), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural ALU ----------------
  function automatic logic [RW-1:0] ref_alu(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                            input logic [2:0] op);
    logic [RW-1:0] wa;
    logic [RW-1:0] wb;
    wa = RW'(a);
    wb = RW'(b);
    case (op)
      OP_ADD:  return wa + wb;
      OP_MUL:  return wa * wb;
      OP_MOD:  return (b == '0) ? wa : (wa % wb);
      OP_AND:  return wa & wb;
      OP_OR:   return wa | wb;
      OP_XOR:  return wa ^ wb;
      OP_SUB:  return wa - wb;
      default: return wa << b[1:0];
    endcase
  endfunction

  always_comb alu_res = ref_alu(alu_a, alu_b, alu_op);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: results compared at the negedge before their handshake edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_stable", 32'({res_op, res_data}), 32'(hold_val));
        hold_pending = 1'b0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_result: got %0h expected none", {res_op, res_data});
        end else begin
          check("result", 32'({res_op, res_data}), 32'(exp_q.pop_front()));
          prev_res_cyc = last_res_cyc;
          last_res_cyc = cyc;
        end
      end else if (res_valid) begin
        hold_pending = 1'b1;
        hold_val     = {res_op, res_data};
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic drive_cmd(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                           input logic [2:0] op, input logic [RW-1:0] exp);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check_cnt++;
      $display("FAIL cmd_accept: got no cmd_ready expected acceptance");
    end else begin
      exp_q.push_back({op, exp});
      accepted++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_cnt++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    accepted = 0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{4'd2,  4'd3,  OP_ADD, 8'd5};
    vecs[1]  = '{4'd3,  4'd4,  OP_MUL, 8'd12};
    vecs[2]  = '{4'd15, 4'd15, OP_ADD, 8'd30};
    vecs[3]  = '{4'd15, 4'd15, OP_MUL, 8'd225};
    vecs[4]  = '{4'd13, 4'd5,  OP_MOD, 8'd3};
    vecs[5]  = '{4'd12, 4'd10, OP_AND, 8'd8};
    vecs[6]  = '{4'd12, 4'd10, OP_OR,  8'd14};
    vecs[7]  = '{4'd12, 4'd10, OP_XOR, 8'd6};
    vecs[8]  = '{4'd12, 4'd10, OP_SUB, 8'd2};
    vecs[9]  = '{4'd3,  4'd5,  OP_SUB, 8'd254};
    vecs[10] = '{4'd9,  4'd3,  OP_SHL, 8'd72};
    vecs[11] = '{4'd7,  4'd0,  OP_MOD, 8'd7};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_op", 32'(res_op), 32'd0);
    check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single command latency: push at k, alu_* at k+1, res_valid at k+2.
    res_ready = 1'b1;
    drive_cmd(4'd2, 4'd3, OP_ADD, 8'd5);
    check("lat_k_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("lat_k_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_k1_alu", 32'({alu_op, alu_a, alu_b}), 32'({OP_ADD, 4'd2, 4'd3}));
    check("lat_k1_valid", 32'(res_valid), 32'd0);
    check("lat_k1_cnt", 32'(issue_cnt), 32'd1);
    @(posedge clk);
    #1;
    check("lat_k2_valid", 32'(res_valid), 32'd1);
    check("lat_k2_data", 32'(res_data), 32'd5);
    check("lat_k2_op", 32'(res_op), 32'(OP_ADD));
    wait_drain();

    // Back-to-back pair: results two cycles apart.
    drive_cmd(4'd3, 4'd4, OP_MUL, 8'd12);
    drive_cmd(4'd15, 4'd15, OP_ADD, 8'd30);
    wait_drain();
    check("b2b_gap", 32'(last_res_cyc - prev_res_cyc), 32'd2);

    for (int i = 0; i < 12; i++) drive_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    wait_drain();
    check("table_issue_cnt", 32'(issue_cnt), 32'(accepted % 256));

    // Backpressure: five commands fill the stage, then drain in order.
    res_ready = 1'b0;
    drive_cmd(4'd1, 4'd1, OP_ADD, 8'd2);
    drive_cmd(4'd2, 4'd2, OP_MUL, 8'd4);
    drive_cmd(4'd9, 4'd4, OP_MOD, 8'd1);
    drive_cmd(4'd6, 4'd3, OP_AND, 8'd2);
    drive_cmd(4'd5, 4'd10, OP_XOR, 8'd15);
    @(negedge clk);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_issue_cnt", 32'(issue_cnt), 32'((accepted - 4) % 256));
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_drain();
    check("bp_ready_back", 32'(cmd_ready), 32'd1);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_issue_done", 32'(issue_cnt), 32'(accepted % 256));

    // Full FIFO with a waiting push while the head is popped.
    res_ready = 1'b0;
    drive_cmd(4'd8, 4'd8, OP_ADD, 8'd16);
    drive_cmd(4'd4, 4'd5, OP_MUL, 8'd20);
    drive_cmd(4'd14, 4'd3, OP_MOD, 8'd2);
    drive_cmd(4'd15, 4'd9, OP_OR, 8'd15);
    drive_cmd(4'd1, 4'd3, OP_SHL, 8'd8);
    res_ready = 1'b1;
    drive_cmd(4'd7, 4'd7, OP_MUL, 8'd49);
    @(negedge clk);
    check("full_refill_ready", 32'(cmd_ready), 32'd0);
    wait_drain();
    check("full_issue_cnt", 32'(issue_cnt), 32'(accepted % 256));

    // Reset while holding a result with three commands queued.
    res_ready = 1'b0;
    drive_cmd(4'd1, 4'd2, OP_ADD, 8'd3);
    drive_cmd(4'd3, 4'd3, OP_MUL, 8'd9);
    drive_cmd(4'd5, 4'd1, OP_SUB, 8'd4);
    drive_cmd(4'd6, 4'd6, OP_XOR, 8'd0);
    @(negedge clk);
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_data", 32'({res_op, res_data}), 32'd0);
    check("mid_rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(issue_cnt), 32'd0);
    exp_q.delete();
    accepted = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({res_valid, busy}), 32'd0);
    end

    // First push lands on the first rising edge after reset release.
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_a = 4'd4; cmd_b = 4'd4; cmd_op = OP_ADD;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.push_back({OP_ADD, 8'd8});
    accepted++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("rel_first_busy", 32'(busy), 32'd1);
    check("rel_first_cnt", 32'(issue_cnt), 32'd0);
    wait_drain();
    check("rel_issue_cnt", 32'(issue_cnt), 32'd1);

    // 256 random commands under random backpressure; counter wraps to 0.
    do_reset();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          logic [OPW-1:0] ra;
          logic [OPW-1:0] rb;
          logic [2:0]     rop;
          ra  = OPW'($urandom_range(0, 15));
          rb  = OPW'($urandom_range(0, 15));
          rop = 3'($urandom_range(0, 7));
          drive_cmd(ra, rb, rop, ref_alu(ra, rb, rop));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    wait_drain();
    check("wrap_issue_cnt", 32'(issue_cnt), 32'd0);
    check("wrap_idle", 32'(fsm_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
